// File: rtl/cnn_3d_pkg.sv
// cnn_3d_pkg: state encodings and error codes shared by the 3D CNN layer scheduler
package cnn_3d_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} job_state_e;
  typedef enum logic [1:0] {C_IDLE, C_START, C_WAIT} conv_state_e;
  typedef enum logic {P_HOLD, P_RUN} pool_state_e;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CONV_TO = 2'b01;
  localparam logic [1:0] ERR_POOL_TO = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;
endpackage

// File: rtl/cnn_3d_watchdog.sv
// cnn_3d_watchdog: counts enabled cycles since clear; expired on the TIMEOUT_CYCLES-th one (0 disables)
module cnn_3d_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && cnt_q != LIM) ? cnt_q + CW'(1) : cnt_q;
  assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt_q == LIM);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cnn_3d_layer_scheduler.sv
// cnn_3d_layer_scheduler: runs conv then pool over N filter groups with ping-pong banks, watchdogs and abort
module cnn_3d_layer_scheduler
  import cnn_3d_pkg::*;
#(
  parameter int MAX_GROUPS     = 16,
  parameter int GRP_W          = $clog2(MAX_GROUPS) + 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [GRP_W-1:0] job_groups,
  input  logic             abort,
  output logic             conv_start,
  input  logic             conv_done,
  output logic             conv_bank,
  output logic             pool_reset,
  input  logic             pool_done,
  output logic             pool_bank,
  output logic [GRP_W-1:0] conv_group,
  output logic [GRP_W-1:0] pool_group,
  output logic             busy,
  output logic             job_done,
  output logic             job_err,
  output logic [1:0]       err_code
);
  localparam logic [GRP_W-1:0] MAXG = GRP_W'(MAX_GROUPS);
  localparam logic [GRP_W-1:0] ONE  = GRP_W'(1);
  job_state_e       job_q, job_d;
  conv_state_e      cs_q, cs_d;
  pool_state_e      ps_q, ps_d;
  logic [GRP_W-1:0] groups_q, groups_d, conv_cnt_q, conv_cnt_d, pool_cnt_q, pool_cnt_d;
  logic             conv_bank_q, conv_bank_d, pool_bank_q, pool_bank_d;
  logic [1:0]       bank_full_q, bank_full_d, err_q, err_d;
  logic             job_ready_q, job_ready_d, busy_q, busy_d;
  logic             conv_start_q, conv_start_d, pool_reset_q, pool_reset_d;
  logic             job_done_q, job_done_d, job_err_q, job_err_d;
  logic             conv_to, pool_to;

  cnn_3d_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_conv_wd (
    .clk(clk), .reset_n(reset_n), .clr(cs_q != C_WAIT), .en(cs_q == C_WAIT), .expired(conv_to)
  );
  cnn_3d_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_pool_wd (
    .clk(clk), .reset_n(reset_n), .clr(ps_q != P_RUN), .en(ps_q == P_RUN), .expired(pool_to)
  );

  // Abort beats timeouts, timeouts beat completion events; bank decisions use registered bank_full.
  always_comb begin
    job_d = job_q;
    cs_d = cs_q;
    ps_d = ps_q;
    groups_d = groups_q;
    conv_cnt_d = conv_cnt_q;
    pool_cnt_d = pool_cnt_q;
    conv_bank_d = conv_bank_q;
    pool_bank_d = pool_bank_q;
    bank_full_d = bank_full_q;
    err_d = err_q;
    case (job_q)
      IDLE: if (job_valid) begin
        groups_d = (job_groups > MAXG) ? MAXG : job_groups;
        conv_cnt_d = '0;
        pool_cnt_d = '0;
        conv_bank_d = 1'b0;
        pool_bank_d = 1'b0;
        bank_full_d = '0;
        err_d = ERR_NONE;
        job_d = (job_groups == '0) ? DONE : RUN;
      end
      RUN: if (abort) begin
        job_d = ERR;
        err_d = ERR_ABORT;
      end else if (conv_to) begin
        job_d = ERR;
        err_d = ERR_CONV_TO;
      end else if (pool_to) begin
        job_d = ERR;
        err_d = ERR_POOL_TO;
      end else if (pool_cnt_q == groups_q) begin
        job_d = DONE;
      end else begin
        if (cs_q == C_IDLE && conv_cnt_q < groups_q && !bank_full_q[conv_bank_q]) cs_d = C_START;
        if (cs_q == C_START) cs_d = C_WAIT;
        if (cs_q == C_WAIT && conv_done) begin
          bank_full_d[conv_bank_q] = 1'b1;
          conv_bank_d = ~conv_bank_q;
          conv_cnt_d = (conv_cnt_q < MAXG) ? conv_cnt_q + ONE : conv_cnt_q;
          cs_d = C_IDLE;
        end
        if (ps_q == P_HOLD && bank_full_q[pool_bank_q]) ps_d = P_RUN;
        if (ps_q == P_RUN && pool_done) begin
          bank_full_d[pool_bank_q] = 1'b0;
          pool_bank_d = ~pool_bank_q;
          pool_cnt_d = (pool_cnt_q < MAXG) ? pool_cnt_q + ONE : pool_cnt_q;
          ps_d = P_HOLD;
        end
      end
      default: job_d = IDLE;
    endcase
    if (job_d != RUN) begin
      cs_d = C_IDLE;
      ps_d = P_HOLD;
    end
    if (job_d == ERR) bank_full_d = '0;
    job_ready_d = job_d == IDLE;
    busy_d = job_d == RUN;
    job_done_d = job_d == DONE;
    job_err_d = job_d == ERR;
    conv_start_d = cs_d == C_START;
    pool_reset_d = ps_d == P_HOLD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      job_q <= IDLE;
      cs_q <= C_IDLE;
      ps_q <= P_HOLD;
      groups_q <= '0;
      conv_cnt_q <= '0;
      pool_cnt_q <= '0;
      conv_bank_q <= 1'b0;
      pool_bank_q <= 1'b0;
      bank_full_q <= '0;
      err_q <= ERR_NONE;
      job_ready_q <= 1'b1;
      busy_q <= 1'b0;
      job_done_q <= 1'b0;
      job_err_q <= 1'b0;
      conv_start_q <= 1'b0;
      pool_reset_q <= 1'b1;
    end else begin
      job_q <= job_d;
      cs_q <= cs_d;
      ps_q <= ps_d;
      groups_q <= groups_d;
      conv_cnt_q <= conv_cnt_d;
      pool_cnt_q <= pool_cnt_d;
      conv_bank_q <= conv_bank_d;
      pool_bank_q <= pool_bank_d;
      bank_full_q <= bank_full_d;
      err_q <= err_d;
      job_ready_q <= job_ready_d;
      busy_q <= busy_d;
      job_done_q <= job_done_d;
      job_err_q <= job_err_d;
      conv_start_q <= conv_start_d;
      pool_reset_q <= pool_reset_d;
    end
  end

  assign job_ready  = job_ready_q;
  assign busy       = busy_q;
  assign job_done   = job_done_q;
  assign job_err    = job_err_q;
  assign conv_start = conv_start_q;
  assign pool_reset = pool_reset_q;
  assign conv_bank  = conv_bank_q;
  assign pool_bank  = pool_bank_q;
  assign conv_group = conv_cnt_q;
  assign pool_group = pool_cnt_q;
  assign err_code   = err_q;
endmodule

// File: tb/tb_cnn_3d_layer_scheduler.sv
// tb_cnn_3d_layer_scheduler: directed jobs against latency-programmable conv/pool engine models
module tb_cnn_3d_layer_scheduler;
  localparam int GW = 5;
  logic clk = 1'b0;
  logic reset_n, job_valid, job_ready, abort, conv_start, conv_done, conv_bank;
  logic pool_reset, pool_done, pool_bank, busy, job_done, job_err;
  logic [GW-1:0] job_groups, conv_group, pool_group;
  logic [1:0] err_code;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int conv_lat = 10;
  int pool_lat = 20;
  bit abort_arm = 1'b0;
  logic pr_prev = 1'b1;
  int st_cyc[$], cd_cyc[$], pf_cyc[$], pd_cyc[$], jd_cyc[$], je_cyc[$];

  cnn_3d_layer_scheduler #(.MAX_GROUPS(16), .GRP_W(GW), .TIMEOUT_CYCLES(64)) u_dut (
    .clk(clk), .reset_n(reset_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_groups(job_groups), .abort(abort), .conv_start(conv_start), .conv_done(conv_done),
    .conv_bank(conv_bank), .pool_reset(pool_reset), .pool_done(pool_done), .pool_bank(pool_bank),
    .conv_group(conv_group), .pool_group(pool_group), .busy(busy), .job_done(job_done),
    .job_err(job_err), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (conv_start) st_cyc.push_back(cyc);
    if (conv_done) cd_cyc.push_back(cyc);
    if (pr_prev && !pool_reset) pf_cyc.push_back(cyc);
    if (pool_done) pd_cyc.push_back(cyc);
    if (job_done) jd_cyc.push_back(cyc);
    if (job_err) je_cyc.push_back(cyc);
    pr_prev <= pool_reset;
  end

  // conv model: done conv_lat cycles after the start pulse; optionally aborts alongside group 2's done
  initial begin
    conv_done = 1'b0;
    abort = 1'b0;
    forever begin
      @(negedge clk);
      if (conv_start) begin
        repeat (conv_lat) @(negedge clk);
        conv_done = 1'b1;
        if (abort_arm && conv_group == 2) abort = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        abort = 1'b0;
      end
    end
  end

  // pool model: runs pool_lat cycles once released, done on the last; pool_lat=0 never finishes
  initial begin
    pool_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!pool_reset && pool_lat != 0) begin
        repeat (pool_lat - 1) @(negedge clk);
        pool_done = 1'b1;
        @(negedge clk);
        pool_done = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_job(input int g, output int a);
    @(negedge clk);
    st_cyc.delete(); cd_cyc.delete(); pf_cyc.delete();
    pd_cyc.delete(); jd_cyc.delete(); je_cyc.delete();
    job_groups = GW'(g);
    job_valid = 1'b1;
    a = cyc;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int lim);
    int n = 0;
    while (!job_ready && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " finishes"}, int'(n < lim), 1);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int a;
    int exp_st[4] = '{2, 14, 45, 76};
    int exp_pf[4] = '{14, 45, 76, 107};
    int exp_pd[4] = '{43, 74, 105, 136};
    reset_n = 1'b1;
    job_valid = 1'b0;
    job_groups = '0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst job_ready", int'(job_ready), 1);
    chk("rst pool_reset", int'(pool_reset), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst conv_start", int'(conv_start), 0);
    chk("rst done/err", int'({job_done, job_err}), 0);
    chk("rst err_code", int'(err_code), 0);
    chk("rst banks", int'({conv_bank, pool_bank}), 0);
    chk("rst groups", int'({conv_group, pool_group}), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    start_job(0, a);
    chk("t1 job_done next cycle", int'(job_done), 1);
    chk("t1 busy", int'(busy), 0);
    chk("t1 pool_reset", int'(pool_reset), 1);
    wait_end("t1", 10);
    chk("t1 conv_starts", st_cyc.size(), 0);
    chk("t1 pool runs", pf_cyc.size(), 0);
    chk("t1 done pulses", jd_cyc.size(), 1);

    conv_lat = 10; pool_lat = 20;
    start_job(1, a);
    wait_end("t2", 100);
    chk("t2 conv_starts", st_cyc.size(), 1);
    chk("t2 conv_start cyc", st_cyc[0] - a, 2);
    chk("t2 pool release cyc", pf_cyc[0] - a, 14);
    chk("t2 pool after conv_done", int'(pf_cyc[0] > cd_cyc[0]), 1);
    chk("t2 job_done cyc", jd_cyc[0] - a, 35);
    chk("t2 conv_bank", int'(conv_bank), 1);
    chk("t2 pool_bank", int'(pool_bank), 1);
    chk("t2 pool_group", int'(pool_group), 1);

    conv_lat = 10; pool_lat = 30;
    start_job(4, a);
    wait_end("t3", 300);
    chk("t3 conv_starts", st_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3 conv_start[%0d]", i), st_cyc[i] - a, exp_st[i]);
      chk($sformatf("t3 pool release[%0d]", i), pf_cyc[i] - a, exp_pf[i]);
      chk($sformatf("t3 pool_done[%0d]", i), pd_cyc[i] - a, exp_pd[i]);
    end
    chk("t3 g2 start after bank0 free", st_cyc[2] - pd_cyc[0], 2);
    chk("t3 job_done cyc", jd_cyc[0] - a, 138);
    chk("t3 pool_group", int'(pool_group), 4);
    chk("t3 conv_group", int'(conv_group), 4);
    chk("t3 banks", int'({conv_bank, pool_bank}), 0);

    conv_lat = 10; pool_lat = 11;
    start_job(2, a);
    wait_cyc(a + 25);
    chk("t4 conv_group", int'(conv_group), 2);
    chk("t4 pool_group", int'(pool_group), 1);
    chk("t4 conv_bank", int'(conv_bank), 0);
    chk("t4 pool_bank", int'(pool_bank), 1);
    wait_end("t4", 100);
    chk("t4 coincident dones", cd_cyc[1] - pd_cyc[0], 0);
    chk("t4 pool release[1]", pf_cyc[1] - a, 26);
    chk("t4 job_done cyc", jd_cyc[0] - a, 38);
    chk("t4 pool_group end", int'(pool_group), 2);

    conv_lat = 10; pool_lat = 0;
    start_job(1, a);
    wait_cyc(a + 78);
    chk("t5 pool release", pf_cyc[0] - a, 14);
    chk("t5 job_err", int'(job_err), 1);
    chk("t5 err_code", int'(err_code), 2);
    chk("t5 pool_reset", int'(pool_reset), 1);
    chk("t5 job_ready in err", int'(job_ready), 0);
    @(negedge clk);
    chk("t5 job_ready after", int'(job_ready), 1);
    chk("t5 err_code held", int'(err_code), 2);
    chk("t5 job_err pulses", je_cyc.size(), 1);
    chk("t5 no job_done", jd_cyc.size(), 0);

    conv_lat = 10; pool_lat = 30; abort_arm = 1'b1;
    start_job(4, a);
    wait_end("t6", 200);
    abort_arm = 1'b0;
    chk("t6 job_err cyc", je_cyc[0] - a, 56);
    chk("t6 err_code", int'(err_code), 3);
    chk("t6 conv_group", int'(conv_group), 2);
    chk("t6 no job_done", jd_cyc.size(), 0);
    chk("t6 conv_starts", st_cyc.size(), 3);
    chk("t6 pool_reset", int'(pool_reset), 1);
    repeat (40) @(negedge clk);
    start_job(2, a);
    wait_cyc(a + 20);
    chk("t6 mid busy", int'(busy), 1);
    chk("t6 mid conv_group", int'(conv_group), 1);
    chk("t6 mid pool_reset", int'(pool_reset), 0);
    chk("t6 err_code cleared", int'(err_code), 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6 async busy", int'(busy), 0);
    chk("t6 async job_ready", int'(job_ready), 1);
    chk("t6 async pool_reset", int'(pool_reset), 1);
    chk("t6 async conv_bank", int'(conv_bank), 0);
    chk("t6 async groups", int'({conv_group, pool_group}), 0);
    chk("t6 async conv_start", int'(conv_start), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6 idle after reset", int'({job_ready, busy}), 2);
    chk("t6 groups after reset", int'({conv_group, pool_group}), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cnn_3d_layer_scheduler.md
Name: cnn_3d_layer_scheduler

Overview:
Sequences one 3D CNN layer: the 3D convolution engine followed by the 3D max-pooling engine, over N filter groups. Ping-pong result banks let conv of group g+1 overlap pooling of group g. The pooling engine is idle while held in its active-high reset and starts when released, so the scheduler drives that reset as its start/hold control. A job handshake from the top-level controller starts the layer. A per-engine watchdog and an abort input guard against hangs.

Parameters:
MAX_GROUPS, 16, maximum filter groups per job
GRP_W, $clog2(MAX_GROUPS)+1, width of group counts (holds 0..MAX_GROUPS)
TIMEOUT_CYCLES, 4096, watchdog limit per engine run; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
job_valid  in  1  job request
job_ready  out  1  scheduler can accept a job
job_groups  in  GRP_W  number of groups, 0..MAX_GROUPS
abort  in  1  synchronous abort of the running job
conv_start  out  1  one-cycle start pulse to the conv engine
conv_done  in  1  one-cycle completion pulse from the conv engine
conv_bank  out  1  bank the conv engine writes
pool_reset  out  1  active-high hold to the pooling engine; 0 means run
pool_done  in  1  pooling done flag, high for one cycle
pool_bank  out  1  bank the pooling engine reads
conv_group  out  GRP_W  group currently or last issued to conv
pool_group  out  GRP_W  group currently or last issued to pool
busy  out  1  job in progress
job_done  out  1  one-cycle pulse: job completed normally
job_err  out  1  one-cycle pulse: job terminated with an error
err_code  out  2  00 none, 01 conv timeout, 10 pool timeout, 11 abort; held until the next job is accepted

Behaviour:
- Reset state while reset_n=0: job FSM in IDLE; pool_reset=1; job_ready=1; all other outputs 0; bank_full[1:0]=0; all counters 0.
- Job FSM states: IDLE, RUN, DONE, ERR.
  - IDLE: job_ready=1.
  - On job_valid&&job_ready: latch job_groups, clear err_code and both counters, set both banks to 0.
  - If job_groups=0: go to DONE and issue no engine activity.
  - Otherwise go to RUN with busy=1.
- Conv sub-FSM states: C_IDLE, C_START, C_WAIT.
  - In RUN, when conv_cnt<groups and bank_full[conv_bank]=0: go to C_START.
  - C_START drives conv_start=1 for exactly one cycle, then goes to C_WAIT.
  - In C_WAIT, on conv_done: set bank_full[conv_bank]=1, toggle conv_bank, increment conv_cnt, return to C_IDLE.
- Pool sub-FSM states: P_HOLD, P_RUN.
  - P_HOLD (pool_reset=1): when bank_full[pool_bank]=1, go to P_RUN, driving pool_reset=0 from the next cycle.
  - In P_RUN, when pool_done is sampled high: pool_reset returns to 1 on that same edge (registered). This hold keeps the engine from relaunching out of its IDLE.
  - Also on that edge: clear bank_full[pool_bank], toggle pool_bank, increment pool_cnt, return to P_HOLD.
- conv_group and pool_group equal conv_cnt and pool_cnt respectively.
- RUN goes to DONE when pool_cnt==groups.
  - DONE: job_done=1 for one cycle, busy=0, then IDLE.
- Start decisions use registered bank_full.
  - A bank freed by pool_done becomes startable one cycle later. This one-cycle bubble is required.
- conv_done and pool_done in the same cycle are legal. They always address different banks, so both updates apply.
- conv_done outside C_WAIT and pool_done outside P_RUN are ignored.
- Watchdog: one counter per engine, cleared on entry to C_WAIT or P_RUN.
  - Reaching TIMEOUT_CYCLES triggers ERR with err_code 01 (conv) or 10 (pool).
  - When both time out in the same cycle, conv wins.
- abort in RUN goes to ERR with err_code 11. Abort has priority over timeout and over done events in the same cycle. abort is ignored in IDLE.
- ERR: pool_reset=1 immediately (registered); conv_start is suppressed; bank_full is cleared. job_err=1 for one cycle, then IDLE.
- reset_n assertion mid-job returns everything to reset values asynchronously.
- Counters saturate at MAX_GROUPS; they never wrap.

Decomposition:
- Package cnn_3d_pkg:
  - job state enum and conv/pool sub-state enums;
  - err_code localparams ERR_NONE, ERR_CONV_TO, ERR_POOL_TO, ERR_ABORT.
- One natural sub-module, cnn_3d_watchdog: clear and enable in, expired out, instantiated twice (conv and pool).

Test Plan:
1. Zero groups: job_groups=0 with job_valid=1 -> job_done the next cycle; conv_start never asserts; pool_reset stays 1.
2. Single group (conv model done after 10 cycles, pool model after 20) -> one conv_start pulse; pool_reset low only after conv_done; job_done after pool_done; conv_bank and pool_bank end at 1.
3. Four groups with conv 10 / pool 30 cycles -> conv of group 1 overlaps pool of group 0.
   - Conv never starts into a full bank; group 2 starts exactly one cycle after pool_done of group 0 frees bank 0.
   - job_done when pool_group=4.
4. Simultaneous conv_done and pool_done in one cycle -> bank_full ends {1,0} or {0,1} as expected; no lost count.
5. Pool model never asserts done, TIMEOUT_CYCLES=64 -> job_err pulse with err_code=10 at pool-run cycle 64; pool_reset=1; job_ready=1 the next cycle.
6. abort in the same cycle as conv_done during group 2 -> err_code=11, no job_done pulse. Then reset_n low mid-job -> all outputs return to reset values without waiting for a clock edge.
